dff: RTL and testbench
======================

Name: dff

Overview:
- Positive-edge D-type register with asynchronous active-low reset.
- Width is configurable; the default is a single bit.
- Provides true and complemented outputs, a clock enable and a synchronous clear.
- Used as the basic storage/pipeline element in datapath and control logic.

Parameters:
- WIDTH, 1, data width in bits (legal range 1..64).
- RST_VAL, 0, value loaded into Q by asynchronous reset; truncated/zero-extended to WIDTH.

Ports:
- clk  input  1  clock; all synchronous activity on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  clock enable; must be tied to 1 when unused.
- clr  input  1  synchronous clear to zero; must be tied to 0 when unused.
- D  input  WIDTH  data input.
- Q  output  WIDTH  registered data.
- Qn  output  WIDTH  bitwise complement of Q.

Behaviour:
- Reset:
  - rst_n=0 forces Q=RST_VAL immediately, independent of clk.
  - Qn=~RST_VAL whenever Q=RST_VAL.
  - Reset dominates en, clr and D.
- Reset release:
  - rst_n rising does not itself change Q.
  - The first capture occurs at the first rising clk edge with rst_n=1.
  - The deassertion edge is not required to be synchronized internally.
- Priority at a rising clk edge with rst_n=1:
  - clr=1: Q<=0, regardless of en.
  - Else en=1: Q<=D (the value sampled at the edge).
  - Else: Q holds.
- Latency: one clock. D changes between edges are invisible until the next rising edge. No transparency while clk is high.
- Qn is purely combinational from Q (~Q), with no additional register stage. Q and Qn are never equal on any bit.
- Falling clk edges have no effect.
- D must be stable around the rising edge (setup/hold per library). Behaviour on simultaneous D and clk transitions in zero-delay simulation: the pre-edge value of D is captured.
- No X propagation from en/clr when rst_n=0.
- Outputs are driven only from the storage element; no combinational D->Q path.
- Must synthesize to flip-flops with asynchronous reset (no latches).

Test Plan:
- Async reset: drive rst_n=0 mid-cycle (clk high, D=1, Q=1) -> Q=0, Qn=1 immediately, before any clk edge. Hold across 3 edges -> Q stays 0.
- Basic capture:
  - Setup: WIDTH=1, clk period 20 (rising edges at 10, 30, 50, ...), rst_n=1, en=1, clr=0.
  - Stimulus: D=0 at t=0, D=1 at t=15, D=0 at t=35, D=1 at t=65, D=0 at t=105.
  - Required Q after edges: Q=0 after edge 10, Q=1 after edge 30, Q=0 after edge 50, Q=1 after edges 70 and 90, Q=0 after edge 110.
  - Qn is always the inverse of Q.
- Enable hold: Q=1, en=0, D toggled every 7 time units for 4 cycles -> Q remains 1. Set en=1 with D=0 -> Q=0 after the next rising edge.
- Synchronous clear priority: Q=8'hA5 (WIDTH=8), clr=1, en=1, D=8'hFF -> Q=8'h00 after the next edge. clr=0 -> Q=8'hFF after the following edge.
- Reset value / release: WIDTH=8, RST_VAL=8'h3C, rst_n=0 -> Q=8'h3C, Qn=8'hC3. Release rst_n between edges with D=8'h11 -> Q stays 8'h3C until the next rising edge, then becomes 8'h11.
- No falling-edge capture: change D only while clk is high and return it before the next rising edge -> Q unchanged.

Source files
------------

// File: rtl/dff.sv
// dff: positive-edge D register with asynchronous active-low reset,
// clock enable, synchronous clear, and true/complement outputs.
//
// Parameters:
//   WIDTH   - data width in bits (1..64)
//   RST_VAL - value loaded by asynchronous reset, truncated to WIDTH
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (dominates everything)
//   en    - clock enable (tie to 1 when unused)
//   clr   - synchronous clear to zero, wins over en (tie to 0 when unused)
//   D     - data input
//   Q     - registered data
//   Qn    - bitwise complement of Q, combinational from the register
module dff #(
    parameter int unsigned WIDTH   = 1,
    parameter logic [63:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= RST_Q;
        end else if (clr) begin
            Q <= '0;
        end else if (en) begin
            Q <= D;
        end
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_dff.sv
// tb_dff: directed self-checking bench for dff. Two instances: a 1-bit
// register with default reset value and an 8-bit register with RST_VAL=8'h3C.
// Clock period 20, rising edges at 10, 30, 50, ...
module tb_dff;

    logic       clk = 1'b0;

    logic       rst_n1 = 1'b1;
    logic       en1    = 1'b1;
    logic       clr1   = 1'b0;
    logic [0:0] d1     = 1'b0;
    logic [0:0] q1;
    logic [0:0] qn1;

    logic       rst_n8 = 1'b1;
    logic       en8    = 1'b1;
    logic       clr8   = 1'b0;
    logic [7:0] d8     = 8'h00;
    logic [7:0] q8;
    logic [7:0] qn8;

    int unsigned npass = 0;
    int unsigned ntot  = 0;

    dff #(
        .WIDTH   (1)
    ) u_dff1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .en    (en1),
        .clr   (clr1),
        .D     (d1),
        .Q     (q1),
        .Qn    (qn1)
    );

    dff #(
        .WIDTH   (8),
        .RST_VAL (64'h3C)
    ) u_dff8 (
        .clk   (clk),
        .rst_n (rst_n8),
        .en    (en8),
        .clr   (clr8),
        .D     (d8),
        .Q     (q8),
        .Qn    (qn8)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) begin
            npass++;
        end else begin
            $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // advance to an absolute simulation time
    task automatic at(input int unsigned t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        // ---------------- 1-bit basic capture ----------------
        at(1);   rst_n1 = 1'b0; rst_n8 = 1'b0;
        at(5);   rst_n1 = 1'b1;
        at(11);  check("cap_e10_q",  q1, 1'b0);  check("cap_e10_qn", qn1, 1'b1);
        at(15);  d1 = 1'b1;
        at(31);  check("cap_e30_q",  q1, 1'b1);  check("cap_e30_qn", qn1, 1'b0);
        at(35);  d1 = 1'b0;
        at(51);  check("cap_e50_q",  q1, 1'b0);  check("cap_e50_qn", qn1, 1'b1);
        at(65);  d1 = 1'b1;
        at(71);  check("cap_e70_q",  q1, 1'b1);
        at(91);  check("cap_e90_q",  q1, 1'b1);  check("cap_e90_qn", qn1, 1'b0);
        at(105); d1 = 1'b0;
        at(111); check("cap_e110_q", q1, 1'b0);

        // ---------------- async reset mid-cycle ----------------
        d1 = 1'b1;
        at(131); check("pre_rst_q", q1, 1'b1);
        at(135); rst_n1 = 1'b0; en1 = 1'bx; clr1 = 1'bx;   // clk high
        at(136); check("async_rst_q", q1, 1'b0);  check("async_rst_qn", qn1, 1'b1);
        at(191); check("rst_hold_q", q1, 1'b0);
        at(195); rst_n1 = 1'b1; en1 = 1'b1; clr1 = 1'b0;
        at(209); check("rel_no_change", q1, 1'b0);
        at(211); check("rel_first_cap", q1, 1'b1);

        // ---------------- enable hold ----------------
        en1 = 1'b0;
        repeat (12) begin
            #7 d1 = ~d1;
        end
        check("en_hold_q", q1, 1'b1);
        d1 = 1'b0; en1 = 1'b1;
        at(305); check("en_before_edge", q1, 1'b1);
        at(311); check("en_capture", q1, 1'b0);  check("en_capture_qn", qn1, 1'b1);

        // ---------------- no capture outside the rising edge ----------------
        at(312); d1 = 1'b1;   // clk high
        at(318); d1 = 1'b0;
        at(319); check("glitch_high", q1, 1'b0);
        at(331); check("glitch_next_edge", q1, 1'b0);
        at(332); d1 = 1'b1;   // held across falling edge at 340
        at(345); check("no_fall_cap", q1, 1'b0);
        d1 = 1'b0;
        at(351); check("fall_then_edge", q1, 1'b0);

        // ---------------- 8-bit reset value / release ----------------
        at(361); check("rv_q", q8, 8'h3C);  check("rv_qn", qn8, 8'hC3);
        d8 = 8'h11;
        at(365); rst_n8 = 1'b1;
        at(369); check("rv_release_hold", q8, 8'h3C);
        at(371); check("rv_first_cap", q8, 8'h11);

        // ---------------- synchronous clear priority ----------------
        d8 = 8'hA5;
        at(391); check("clr_setup", q8, 8'hA5);
        clr8 = 1'b1; d8 = 8'hFF;
        at(411); check("clr_q", q8, 8'h00);  check("clr_qn", qn8, 8'hFF);
        clr8 = 1'b0;
        at(431); check("clr_release", q8, 8'hFF);
        clr8 = 1'b1; en8 = 1'b0;
        at(451); check("clr_no_en", q8, 8'h00);
        clr8 = 1'b0; en8 = 1'b1; d8 = 8'h5A;
        at(455); rst_n8 = 1'b0;   // clk high
        at(456); check("rst8_async", q8, 8'h3C);  check("rst8_async_qn", qn8, 8'hC3);
        at(471); check("rst8_hold", q8, 8'h3C);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
